atto_output_arbiter: RTL and testbench

//  Per-output-port arbiter for the atto router. Shares one output channel (south or west)

---
 rtl/atto_output_arbiter.sv | 160 ++++++++++++++++
 tb/tb_atto_output_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atto_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : atto_output_arbiter                                          |
// | Description : Per-output-port arbiter for the atto router. Shares one      |
// |               output channel between north, east and PE requesters, one    |
// |               single-flit packet per grant. Tracks downstream credits.     |
// | Build macro : ATTO_ARB_FIXED_PRIO_EN - fixed priority N > E > PE instead   |
// |               of round-robin (no rr pointer; PE can starve).               |
// | Ports       : clka/rsta           clock / async active-high reset          |
// |               req_din[2:0]        requests [0] N, [1] E, [2] PE            |
// |               credit_return_din   one downstream credit returned           |
// |               grant_dout/ack_dout registered one-hot grant / ack           |
// |               xbar_sel_dout       0 N, 1 E, 2 PE, 3 none                   |
// |               out_valid_dout      output flit valid                        |
// |               credits_dout        current credit count                     |
// |               stall_dout          waiting for credits                      |
// |               credit_err_dout     sticky credit overflow flag              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module atto_output_arbiter #(
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic [2:0]       req_din,
  input  logic             credit_return_din,
  output logic [2:0]       grant_dout,
  output logic [2:0]       ack_dout,
  output logic [1:0]       xbar_sel_dout,
  output logic             out_valid_dout,
  output logic [CNT_W-1:0] credits_dout,
  output logic             stall_dout,
  output logic             credit_err_dout
);

  localparam logic [CNT_W-1:0] c_credit_max = CNT_W'(CREDITS);
  localparam logic [1:0]       c_sel_none   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_grant;
  logic [1:0]       r_xbar_sel;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_credits;
  logic             r_stall;
  logic             r_credit_err;

  logic [2:0]       w_eff;
  logic             w_eff_any;
  logic             w_cred_zero;
  logic             w_do_grant;
  logic [1:0]       w_pick_idx;
  logic [2:0]       w_pick_oh;

  // The requester granted last cycle still shows its request this cycle;
  // masking it with the current grant avoids a double grant.
  assign w_eff       = req_din & ~r_grant;
  assign w_eff_any   = |w_eff;
  assign w_cred_zero = (r_credits == '0);
  assign w_pick_oh   = 3'b001 << w_pick_idx;

`ifdef ATTO_ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick_idx = 2'd0;
    if (w_eff[0])      w_pick_idx = 2'd0;
    else if (w_eff[1]) w_pick_idx = 2'd1;
    else if (w_eff[2]) w_pick_idx = 2'd2;
  end
`else
  logic [1:0] r_rr_ptr;
  logic [2:0] w_cand;
  logic       w_found;

  // Search starts at the rr pointer and wraps N -> E -> PE.
  always_comb begin
    w_pick_idx = 2'd0;
    w_found    = 1'b0;
    w_cand     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      w_cand = {1'b0, r_rr_ptr} + 3'(k);
      if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
      if (!w_found && w_eff[w_cand[1:0]]) begin
        w_found    = 1'b1;
        w_pick_idx = w_cand[1:0];
      end
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_rr_ptr <= 2'd0;
    end else if (w_do_grant) begin
      r_rr_ptr <= (w_pick_idx == 2'd2) ? 2'd0 : w_pick_idx + 2'd1;
    end
  end
`endif

  // In STALL an empty credit count dominates, even if the request went away.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_STALL: begin
        if (w_cred_zero)    w_next = S_STALL;
        else if (w_eff_any) w_next = S_GRANT;
        else                w_next = S_IDLE;
      end
      default: begin
        if (!w_eff_any)       w_next = S_IDLE;
        else if (!w_cred_zero) w_next = S_GRANT;
        else                  w_next = S_STALL;
      end
    endcase
  end

  assign w_do_grant = (w_next == S_GRANT);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state      <= S_IDLE;
      r_grant      <= 3'b000;
      r_xbar_sel   <= c_sel_none;
      r_out_valid  <= 1'b0;
      r_credits    <= c_credit_max;
      r_stall      <= 1'b0;
      r_credit_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_grant     <= w_do_grant ? w_pick_oh : 3'b000;
      r_xbar_sel  <= w_do_grant ? w_pick_idx : c_sel_none;
      r_out_valid <= w_do_grant;
      r_stall     <= (w_next == S_STALL);
      // A grant and a return in the same cycle cancel out.
      case ({w_do_grant, credit_return_din})
        2'b10: r_credits <= r_credits - 1'b1;
        2'b01: begin
          if (r_credits == c_credit_max) r_credit_err <= 1'b1;
          else                           r_credits    <= r_credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant_dout      = r_grant;
  assign ack_dout        = r_grant;
  assign xbar_sel_dout   = r_xbar_sel;
  assign out_valid_dout  = r_out_valid;
  assign credits_dout    = r_credits;
  assign stall_dout      = r_stall;
  assign credit_err_dout = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_atto_output_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_atto_output_arbiter                                       |
// | Description : Scenario bench for atto_output_arbiter. Expected grants are  |
// |               queued when requests are driven and matched against grants   |
// |               observed on the output.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_atto_output_arbiter;

  logic       clka;
  logic       rsta;
  logic [2:0] req;
  logic       ret;
  logic [2:0] grant_dout;
  logic [2:0] ack_dout;
  logic [1:0] xbar_sel_dout;
  logic       out_valid_dout;
  logic [2:0] credits_dout;
  logic       stall_dout;
  logic       credit_err_dout;

  int checks;
  int errors;

  // Observed entry: {valid, xbar_sel, ack, grant}
  logic [8:0] obs_q[$];
  logic [2:0] exp_q[$];

  atto_output_arbiter #(.CREDITS(4), .CNT_W(3)) dut (
    .clka              (clka),
    .rsta              (rsta),
    .req_din           (req),
    .credit_return_din (ret),
    .grant_dout        (grant_dout),
    .ack_dout          (ack_dout),
    .xbar_sel_dout     (xbar_sel_dout),
    .out_valid_dout    (out_valid_dout),
    .credits_dout      (credits_dout),
    .stall_dout        (stall_dout),
    .credit_err_dout   (credit_err_dout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // One clock: sample just after the edge, record grants, requesters drop on ack.
  task automatic step();
    @(posedge clka);
    #1;
    if (grant_dout != 3'b000)
      obs_q.push_back({out_valid_dout, xbar_sel_dout, ack_dout, grant_dout});
    req = req & ~ack_dout;
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    req  = 3'b000;
    ret  = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    rsta = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    req  = 3'b000;
    ret  = 1'b0;
    repeat (20) @(posedge clka);
    #1;
    rsta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({grant_dout, ack_dout, xbar_sel_dout, out_valid_dout, credits_dout, stall_dout, credit_err_dout}
          !== {3'b000, 3'b000, 2'd3, 1'b0, 3'd4, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state cyc%0d got g=%b a=%b x=%0d v=%b c=%0d s=%b e=%b exp g=000 a=000 x=3 v=0 c=4 s=0 e=0",
                 i, grant_dout, ack_dout, xbar_sel_dout, out_valid_dout, credits_dout, stall_dout, credit_err_dout);
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] e;
    logic [8:0] o;
    do_reset();
    req = 3'b001;
    exp_q.push_back(3'b001);
    step();
    checks++;
    if ({grant_dout, xbar_sel_dout, credits_dout} !== {3'b001, 2'd0, 3'd3}) begin
      errors++;
      $display("FAIL single_grant got g=%b x=%0d c=%0d exp g=001 x=0 c=3", grant_dout, xbar_sel_dout, credits_dout);
    end
    step();
    checks++;
    if ({grant_dout, stall_dout, credits_dout} !== {3'b000, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL single_idle got g=%b s=%b c=%0d exp g=000 s=0 c=3", grant_dout, stall_dout, credits_dout);
    end
    step();
    ret = 1'b1;
    step();
    ret = 1'b0;
    checks++;
    if ({credits_dout, credit_err_dout} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL single_refill got c=%0d e=%b exp c=4 e=0", credits_dout, credit_err_dout);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b1, sel_of(e), e, e}) begin
        errors++;
        $display("FAIL single_sb got %b exp %b", o, {1'b1, sel_of(e), e, e});
      end
    end
  endtask

  task automatic test_all_three();
    logic [2:0] e;
    logic [8:0] o;
    do_reset();
    req = 3'b111;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    repeat (5) step();
    checks++;
    if (credits_dout !== 3'd1) begin
      errors++;
      $display("FAIL three_credits got %0d exp 1", credits_dout);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL three_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b1, sel_of(e), e, e}) begin
        errors++;
        $display("FAIL three_sb got %b exp %b", o, {1'b1, sel_of(e), e, e});
      end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] e;
    logic [8:0] o;
    do_reset();
    req = 3'b101;
    ret = 1'b1;
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    for (int i = 0; i < 4; i++) begin
      step();
      req = 3'b101;
    end
    req = 3'b000;
    ret = 1'b0;
    repeat (2) step();
    checks++;
    if ({credits_dout, credit_err_dout} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL fair_credits got c=%0d e=%b exp c=4 e=0", credits_dout, credit_err_dout);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fair_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b1, sel_of(e), e, e}) begin
        errors++;
        $display("FAIL fair_sb got %b exp %b", o, {1'b1, sel_of(e), e, e});
      end
    end
  endtask

  task automatic test_stall();
    logic [2:0] e;
    logic [8:0] o;
    do_reset();
    req = 3'b010;
    repeat (4) exp_q.push_back(3'b010);
    for (int i = 0; i < 9; i++) begin
      step();
      req = 3'b010;
    end
    checks++;
    if ({stall_dout, grant_dout, credits_dout} !== {1'b1, 3'b000, 3'd0}) begin
      errors++;
      $display("FAIL stall_enter got s=%b g=%b c=%0d exp s=1 g=000 c=0", stall_dout, grant_dout, credits_dout);
    end
    ret = 1'b1;
    step();
    ret = 1'b0;
    checks++;
    if ({stall_dout, grant_dout, credits_dout} !== {1'b1, 3'b000, 3'd1}) begin
      errors++;
      $display("FAIL stall_return got s=%b g=%b c=%0d exp s=1 g=000 c=1", stall_dout, grant_dout, credits_dout);
    end
    exp_q.push_back(3'b010);
    step();
    checks++;
    if ({stall_dout, grant_dout, credits_dout} !== {1'b0, 3'b010, 3'd0}) begin
      errors++;
      $display("FAIL stall_release got s=%b g=%b c=%0d exp s=0 g=010 c=0", stall_dout, grant_dout, credits_dout);
    end
    step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b1, sel_of(e), e, e}) begin
        errors++;
        $display("FAIL stall_sb got %b exp %b", o, {1'b1, sel_of(e), e, e});
      end
    end
  endtask

  task automatic test_saturation_and_reset();
    logic [2:0] e;
    logic [8:0] o;
    do_reset();
    ret = 1'b1;
    step();
    ret = 1'b0;
    checks++;
    if ({credits_dout, credit_err_dout} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL sat_err got c=%0d e=%b exp c=4 e=1", credits_dout, credit_err_dout);
    end
    repeat (3) step();
    checks++;
    if (credit_err_dout !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky got %b exp 1", credit_err_dout);
    end
    req = 3'b001;
    exp_q.push_back(3'b001);
    step();
    checks++;
    if ({grant_dout, credits_dout} !== {3'b001, 3'd3}) begin
      errors++;
      $display("FAIL midgrant_pre got g=%b c=%0d exp g=001 c=3", grant_dout, credits_dout);
    end
    #2;
    rsta = 1'b1;
    #1;
    checks++;
    if ({grant_dout, ack_dout, xbar_sel_dout, out_valid_dout, credits_dout, stall_dout, credit_err_dout}
        !== {3'b000, 3'b000, 2'd3, 1'b0, 3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got g=%b a=%b x=%0d v=%b c=%0d s=%b e=%b exp g=000 a=000 x=3 v=0 c=4 s=0 e=0",
               grant_dout, ack_dout, xbar_sel_dout, out_valid_dout, credits_dout, stall_dout, credit_err_dout);
    end
    @(posedge clka);
    #1;
    rsta = 1'b0;
    step();
    checks++;
    if ({grant_dout, credits_dout} !== {3'b000, 3'd4}) begin
      errors++;
      $display("FAIL post_reset got g=%b c=%0d exp g=000 c=4", grant_dout, credits_dout);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL sat_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== {1'b1, sel_of(e), e, e}) begin
        errors++;
        $display("FAIL sat_sb got %b exp %b", o, {1'b1, sel_of(e), e, e});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rsta   = 1'b1;
    req    = 3'b000;
    ret    = 1'b0;
    test_reset();
    test_single();
    test_all_three();
    test_fairness();
    test_stall();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
